// File: rtl/uart_flag_ctrl_if.sv
// Flag/interrupt bundle between the UART engines + CPU side and uart_flag_ctrl.
// master: engines/CPU drive set/clear/enable/ack and observe flags/irq.
// slave: the flag controller itself.
interface uart_flag_ctrl_if #(
  parameter int NUM_FLAGS = 4,
  parameter int VEC_W     = 2
);
  logic [NUM_FLAGS-1:0] set_req;
  logic [NUM_FLAGS-1:0] clr_req;
  logic [NUM_FLAGS-1:0] int_en;
  logic                 irq_ack;
  logic [NUM_FLAGS-1:0] flags;
  logic                 irq;
  logic [VEC_W-1:0]     irq_vec;
  logic [NUM_FLAGS-1:0] ovr;

  modport master (
    output set_req, clr_req, int_en, irq_ack,
    input  flags, irq, irq_vec, ovr
  );

  modport slave (
    input  set_req, clr_req, int_en, irq_ack,
    output flags, irq, irq_vec, ovr
  );
endinterface

// File: rtl/uart_flag_ctrl.sv
// Purpose: UART status flags with round-robin interrupt scheduling; optional overrun via UART_FLAG_OVR_EN.
// Latency: set_req -> flags 1 cycle, -> irq 2 cycles; irq low for one GAP cycle after each service.
// Backpressure: irq held until irq_ack or withdraw; set events never stall and win over clears.
module uart_flag_ctrl #(
  parameter int NUM_FLAGS = 4,
  parameter int VEC_W     = 2
) (
  input  logic           clk,
  input  logic           reset,
  uart_flag_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t               state_q, state_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [VEC_W-1:0]     rr_q, rr_d;
  logic [VEC_W-1:0]     vec_q, vec_d;
  logic                 irq_q, irq_d;
  logic [NUM_FLAGS-1:0] pend;
  logic [VEC_W-1:0]     pick;
  logic                 found;
  logic                 grant_pend;
  logic                 ack_clr;
  int                   idx;

  assign pend = flags_q & bus.int_en;

  // Round-robin pick: first pending flag scanning from rr upward with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_FLAGS) idx = idx - NUM_FLAGS;
      for (int j = 0; j < NUM_FLAGS; j++) begin
        if (!found && (j == idx) && pend[j]) begin
          found = 1'b1;
          pick  = VEC_W'(j);
        end
      end
    end
  end

  // Is the flag currently being serviced still pending (not cleared or masked)?
  always_comb begin
    grant_pend = 1'b0;
    for (int j = 0; j < NUM_FLAGS; j++) begin
      if (VEC_W'(j) == vec_q) grant_pend = pend[j];
    end
  end

  // Arbiter FSM next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    vec_d   = vec_q;
    rr_d    = rr_q;
    ack_clr = 1'b0;
    case (state_q)
      IDLE: begin
        irq_d = 1'b0;
        if (found) begin
          irq_d   = 1'b1;
          vec_d   = pick;
          state_d = REQ;
        end
      end
      REQ: begin
        irq_d = 1'b1;
        if (bus.irq_ack) begin
          ack_clr = 1'b1;
          rr_d    = (vec_q == VEC_W'(NUM_FLAGS - 1)) ? '0 : vec_q + VEC_W'(1);
          irq_d   = 1'b0;
          state_d = GAP;
        end else if (!grant_pend) begin
          // Withdraw: the flag went away before the CPU serviced it.
          irq_d   = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Per-flag set/clear; a set in the same cycle as any clear keeps the flag.
  always_comb begin
    flags_d = flags_q;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (bus.set_req[i]) begin
        flags_d[i] = 1'b1;
      end else if (bus.clr_req[i] || (ack_clr && (vec_q == VEC_W'(i)))) begin
        flags_d[i] = 1'b0;
      end
    end
  end

  // State, flag and interrupt registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      flags_q <= '0;
      rr_q    <= '0;
      vec_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      rr_q    <= rr_d;
      vec_q   <= vec_d;
      irq_q   <= irq_d;
    end
  end

`ifdef UART_FLAG_OVR_EN
  logic [NUM_FLAGS-1:0] ovr_q, ovr_d;

  // Sticky overrun: a set arriving on an already-set flag means an event was lost.
  always_comb begin
    ovr_d = ovr_q;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (bus.set_req[i] && flags_q[i]) begin
        ovr_d[i] = 1'b1;
      end else if (bus.clr_req[i] && !bus.set_req[i]) begin
        ovr_d[i] = 1'b0;
      end
    end
  end

  // Overrun registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign bus.ovr = ovr_q;
`else
  assign bus.ovr = '0;
`endif

  assign bus.flags   = flags_q;
  assign bus.irq     = irq_q;
  assign bus.irq_vec = vec_q;

endmodule
